pcie_irq_src_ctrl: RTL and testbench

Upstream of the XDMA user-interrupt request/ack handler. Collects N_SRC user event lines (DMA frame-done, FIFO errors, etc.) into a sticky, maskable pending register, and produces a clean user_irq_req_o pulse train. Each request is a rising edge held long enough for the downstream 3-flop synchroniser. The block tracks XDMA acknowledge to pace requests, retries on timeout, and exposes status, overflow and count to the host register file.

---
 rtl/pcie_irq_src_ctrl.sv | 100 ++++++++++
 tb/tb_pcie_irq_src_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pcie_irq_src_ctrl.sv
// pcie_irq_src_ctrl: sticky maskable interrupt pending register driving a paced,
// ack-tracked user_irq_req_o pulse train for the XDMA user interrupt handler.
module pcie_irq_src_ctrl #(
   parameter int N_SRC = 4,
   parameter int REQ_HOLD = 8,
   parameter int GAP_CYC = 8,
   parameter int ACK_TO_W = 16,
   parameter logic [ACK_TO_W-1:0] ACK_TIMEOUT = 16'd50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] evt_i,
   input  logic [N_SRC-1:0] irq_mask_i,
   input  logic             irq_clr_vld_i,
   input  logic [N_SRC-1:0] irq_clr_i,
   input  logic             xdma_irq_ack_i,
   output logic             user_irq_req_o,
   output logic [N_SRC-1:0] irq_pending_o,
   output logic [N_SRC-1:0] irq_vec_o,
   output logic [N_SRC-1:0] irq_ovf_o,
   output logic             ack_to_err_o,
   output logic [15:0]      irq_cnt_o
);
   localparam int HW = $clog2(REQ_HOLD > GAP_CYC ? REQ_HOLD : GAP_CYC) + 1;
   localparam logic [HW-1:0] REQ_LAST = HW'(REQ_HOLD - 1);
   localparam logic [HW-1:0] GAP_LAST = HW'(GAP_CYC - 1);
   localparam logic [ACK_TO_W-1:0] TO_LAST = ACK_TIMEOUT - 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, GAP} state_t;

   state_t state, state_d;
   logic [HW-1:0] hold_cnt, hold_d;
   logic [ACK_TO_W-1:0] to_cnt, to_d;
   logic [N_SRC-1:0] evt_r, rise, clr_m, active;
   logic [2:0] ack_s;
   logic ack_rise, launch, to_hit;

   assign rise = evt_i & ~evt_r;
   assign clr_m = irq_clr_vld_i ? irq_clr_i : '0;
   assign active = irq_pending_o & irq_mask_i;
   // ack_s[1:0] is the synchroniser, ack_s[2] the edge-detect delay
   assign ack_rise = ack_s[1] & ~ack_s[2];

   always_comb begin
      state_d = state;
      hold_d = hold_cnt + 1'b1;
      to_d = '0;
      launch = 1'b0;
      to_hit = 1'b0;
      case (state)
         IDLE: begin
            hold_d = '0;
            launch = |active;
            state_d = launch ? REQ : IDLE;
         end
         REQ: begin
            state_d = hold_cnt == REQ_LAST ? WAIT_ACK : REQ;
         end
         WAIT_ACK: begin
            hold_d = '0;
            to_d = to_cnt + 1'b1;
            to_hit = !ack_rise && to_cnt == TO_LAST;
            state_d = ack_rise || to_hit ? GAP : WAIT_ACK;
         end
         default: begin
            state_d = hold_cnt == GAP_LAST ? IDLE : GAP;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hold_cnt <= '0;
         to_cnt <= '0;
         evt_r <= '0;
         ack_s <= '0;
         user_irq_req_o <= 1'b0;
         irq_pending_o <= '0;
         irq_vec_o <= '0;
         irq_ovf_o <= '0;
         ack_to_err_o <= 1'b0;
         irq_cnt_o <= '0;
      end else begin
         state <= state_d;
         hold_cnt <= hold_d;
         to_cnt <= to_d;
         evt_r <= evt_i;
         ack_s <= {ack_s[1:0], xdma_irq_ack_i};
         user_irq_req_o <= state_d == REQ;
         irq_pending_o <= (irq_pending_o & ~clr_m) | rise;
         irq_ovf_o <= (irq_ovf_o & ~clr_m) | (rise & irq_pending_o);
         ack_to_err_o <= to_hit | (ack_to_err_o & ~(irq_clr_vld_i & |irq_clr_i));
         if (launch) begin
            irq_vec_o <= active;
            irq_cnt_o <= irq_cnt_o + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pcie_irq_src_ctrl.sv
// tb_pcie_irq_src_ctrl: directed scenarios plus random traffic, checked every cycle
// against a timestamp-based reference model of the request sequencing.
module tb_pcie_irq_src_ctrl;
   localparam int N = 4, R = 8, G = 8, AT = 20;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0] evt = '0, mask = '0, clr = '0;
   logic clr_vld = 1'b0, ack = 1'b0;
   logic req, err;
   logic [N-1:0] pend, vec, ovf;
   logic [15:0] cnt;
   int checks = 0, errors = 0;

   logic [N-1:0] m_pend, m_ovf, m_vec, m_evt_prev;
   logic [15:0] m_cnt;
   logic [2:0] ah;
   logic m_err, m_req;
   bit busy;
   int n = 0, t_l, t_g;

   always #5 clk = ~clk;

   pcie_irq_src_ctrl #(
      .N_SRC(N), .REQ_HOLD(R), .GAP_CYC(G), .ACK_TO_W(16), .ACK_TIMEOUT(16'(AT))
   ) dut (
      .clk(clk), .rst_n(rst_n), .evt_i(evt), .irq_mask_i(mask),
      .irq_clr_vld_i(clr_vld), .irq_clr_i(clr), .xdma_irq_ack_i(ack),
      .user_irq_req_o(req), .irq_pending_o(pend), .irq_vec_o(vec),
      .irq_ovf_o(ovf), .ack_to_err_o(err), .irq_cnt_o(cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_pend = '0; m_ovf = '0; m_vec = '0; m_evt_prev = '0;
      m_cnt = '0; ah = '0; m_err = 1'b0; m_req = 1'b0;
      busy = 1'b0; t_l = 0; t_g = -1;
   endtask

   // Sequence timing is tracked as edge timestamps: launch at t_l, REQ for R
   // edges, waiting until ack or AT edges elapse (t_g), then G gap edges.
   task automatic m_edge();
      logic [N-1:0] rise, cm, act;
      logic ar, hit;
      hit = 1'b0;
      rise = evt & ~m_evt_prev;
      cm = clr_vld ? clr : '0;
      act = m_pend & mask;
      ar = ah[1] & ~ah[2];
      if (!busy) begin
         if (act != '0) begin
            busy = 1'b1; t_l = n; t_g = -1; m_vec = act; m_cnt = m_cnt + 16'd1;
         end
      end else if (t_g < 0) begin
         if (n > t_l + R) begin
            if (ar) t_g = n;
            else if (n == t_l + R + AT) begin t_g = n; hit = 1'b1; end
         end
      end else if (n == t_g + G) busy = 1'b0;
      m_err = hit | (m_err & !(clr_vld && clr != '0));
      m_ovf = (m_ovf & ~cm) | (rise & m_pend);
      m_pend = (m_pend & ~cm) | rise;
      m_evt_prev = evt;
      ah = {ah[1:0], ack};
      m_req = busy && t_g < 0 && (n - t_l) < R;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_edge();
      n++;
      #1;
      check("req", 32'(req), 32'(m_req));
      check("pend", 32'(pend), 32'(m_pend));
      check("vec", 32'(vec), 32'(m_vec));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("err", 32'(err), 32'(m_err));
      check("cnt", 32'(cnt), 32'(m_cnt));
   endtask

   initial begin
      m_reset();
      for (int i = 0; i < 6; i++) begin evt = 4'(i); step(); end
      check("rst_req", 32'(req), 0);
      check("rst_pend", 32'(pend), 0);
      check("rst_cnt", 32'(cnt), 0);
      evt = '0; step();
      rst_n = 1'b1; mask = 4'hF; step();
      // single event, launch latency and hold length
      evt = 4'h1; step(); evt = '0;
      check("t1_pend", 32'(pend), 1);
      check("t1_req_early", 32'(req), 0);
      step();
      check("t1_req", 32'(req), 1);
      check("t1_vec", 32'(vec), 1);
      check("t1_cnt", 32'(cnt), 1);
      repeat (R - 1) step();
      check("t1_req_hold", 32'(req), 1);
      step();
      check("t1_req_end", 32'(req), 0);
      // ack during WAIT_ACK then host clear: no relaunch
      ack = 1'b1; repeat (3) step(); ack = 1'b0;
      clr_vld = 1'b1; clr = 4'h1; step(); clr_vld = 1'b0; clr = '0;
      check("t2_pend", 32'(pend), 0);
      repeat (30) step();
      check("t2_req", 32'(req), 0);
      check("t2_cnt", 32'(cnt), 1);
      check("t2_err", 32'(err), 0);
      // masked source with overflow, then unmask
      mask = 4'hE;
      evt = 4'h1; step(); evt = '0; step(); evt = 4'h1; step(); evt = '0; step();
      check("t3_pend", 32'(pend), 1);
      check("t3_ovf", 32'(ovf), 1);
      repeat (5) step();
      check("t3_req_masked", 32'(req), 0);
      mask = 4'hF; step();
      check("t3_req", 32'(req), 1);
      check("t3_vec", 32'(vec), 1);
      check("t3_cnt", 32'(cnt), 2);
      clr_vld = 1'b1; clr = 4'h1; step(); clr_vld = 1'b0; clr = '0;
      check("t3_ovf_clr", 32'(ovf), 0);
      repeat (40) step();
      check("t3_err", 32'(err), 1);
      clr_vld = 1'b1; clr = 4'hF; step(); clr_vld = 1'b0; clr = '0;
      check("t3_err_clr", 32'(err), 0);
      // ack timeout and retry
      evt = 4'h4; step(); evt = '0; step();
      check("t4_cnt1", 32'(cnt), 3);
      repeat (27) step();
      check("t4_err_early", 32'(err), 0);
      step();
      check("t4_err", 32'(err), 1);
      repeat (G) step();
      check("t4_gap", 32'(req), 0);
      step();
      check("t4_retry", 32'(req), 1);
      check("t4_cnt2", 32'(cnt), 4);
      clr_vld = 1'b1; clr = 4'h4; step(); clr_vld = 1'b0; clr = '0;
      check("t4_pend_clr", 32'(pend), 0);
      check("t4_err_clr", 32'(err), 0);
      repeat (45) step();
      clr_vld = 1'b1; clr = 4'hF; step(); clr_vld = 1'b0; clr = '0;
      // simultaneous set and clear, then reset in the 3rd REQ cycle
      evt = 4'h2; clr_vld = 1'b1; clr = 4'h2; step();
      evt = '0; clr_vld = 1'b0; clr = '0;
      check("t5_set_wins", 32'(pend[1]), 1);
      repeat (3) step();
      check("t6_in_req", 32'(req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_req_async", 32'(req), 0);
      check("t6_cnt_async", 32'(cnt), 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (30) step();
      check("t6_no_req", 32'(req), 0);
      check("t6_cnt", 32'(cnt), 0);
      // random traffic
      mask = 4'hF;
      repeat (3000) begin
         evt = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 49) == 0) mask = 4'($urandom);
         clr_vld = ($urandom_range(0, 19) == 0);
         clr = 4'($urandom);
         if ($urandom_range(0, 7) == 0) ack = ~ack;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
